// File: rtl/fft_butterfly_stage.sv
// One radix-2 DIF stage of the FFT32 datapath: buffers the mapper's twiddle triples,
// then runs N/2 in-place butterflies against an external 1-cycle-latency sample RAM.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; latches stage index and clears k
// LOAD  | capturing coefficient triples until coef_done
// RD_A  | mem_raddr = a
// RD_B  | mem_raddr = b; xa captured from read data
// CAP_B | xb captured from read data
// MUL   | half-sum and 3-multiplier twiddle product registered
// WR_A  | write half-sum to a
// WR_B  | write rotated difference to b; next k or finish
// DONE  | one-cycle done pulse
module fft_butterfly_stage #(
  parameter int N    = 32,
  parameter int MSB  = 16,
  parameter int FRAC = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [$clog2(N/4)-1:0]  stage_i,
  input  logic                    coef_we_i,
  input  logic [$clog2(N/2)-1:0]  coef_addr_i,
  input  logic [MSB-1:0]          c_i,
  input  logic [MSB-1:0]          cps_i,
  input  logic [MSB-1:0]          cms_i,
  input  logic                    coef_done_i,
  output logic [$clog2(N)-1:0]    mem_raddr_o,
  input  logic [MSB-1:0]          mem_rdata_re_i,
  input  logic [MSB-1:0]          mem_rdata_im_i,
  output logic                    mem_we_o,
  output logic [$clog2(N)-1:0]    mem_waddr_o,
  output logic [MSB-1:0]          mem_wdata_re_o,
  output logic [MSB-1:0]          mem_wdata_im_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int AW = $clog2(N);
  localparam int KW = $clog2(N/2);
  localparam int SW = $clog2(N/4);
  localparam int CW = 3*MSB;
  localparam int W1 = MSB + 1;
  localparam int ZW = 2*MSB + 1;
  localparam int PW = 2*MSB + 2;
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RD_A, S_RD_B, S_CAP_B, S_MUL, S_WR_A, S_WR_B, S_DONE
  } state_t;

  state_t state_q;
  logic [SW-1:0] stage_q;
  logic [KW-1:0] k_q;
  logic signed [MSB-1:0] xa_re_q, xa_im_q, xb_re_q, xb_im_q;
  logic [MSB-1:0] bf_re_q, bf_im_q;
  logic [MSB-1:0] wd_re_q, wd_im_q;
  logic [AW-1:0]  raddr_q, waddr_q;
  logic           we_q, busy_q, done_q;

  logic [CW-1:0] coef_mem_q [N/2];

  // half - 1 for the current stage; doubles as the mask for j = k mod half
  function automatic logic [AW-1:0] half_m1(input logic [SW-1:0] s);
    return AW'((N >> (int'(s) + 1)) - 1);
  endfunction

  // a = 2*half*g + j, rewritten as 2k - j
  function automatic logic [AW-1:0] addr_a(input logic [KW-1:0] k,
                                           input logic [AW-1:0] hm1);
    logic [AW-1:0] kk;
    kk = AW'(k);
    return (kk << 1) - (kk & hm1);
  endfunction

  logic [AW-1:0] hm1_d, a_d, b_d, a_nxt_d;
  logic [KW-1:0] k_nxt_d;

  always_comb begin
    hm1_d   = half_m1(stage_q);
    k_nxt_d = k_q + KW'(1);
    a_d     = addr_a(k_q, hm1_d);
    b_d     = a_d + hm1_d + AW'(1);
    a_nxt_d = addr_a(k_nxt_d, hm1_d);
  end

  logic [CW-1:0] coef_w;
  logic signed [MSB-1:0] c_s, cps_s, cms_s;
  logic signed [W1-1:0]  add_re, add_im, sub_re, sub_im, dd;
  logic signed [MSB-1:0] d_re, d_im;
  logic signed [ZW-1:0]  z;
  logic signed [PW-1:0]  pre_re, pre_im;
  logic [MSB-1:0] sum_re_d, sum_im_d, bf_re_d, bf_im_d;

  assign coef_w = coef_mem_q[k_q];
  assign c_s    = coef_w[3*MSB-1:2*MSB];
  assign cps_s  = coef_w[2*MSB-1:MSB];
  assign cms_s  = coef_w[MSB-1:0];

  always_comb begin
    add_re   = W1'(xa_re_q) + W1'(xb_re_q);
    add_im   = W1'(xa_im_q) + W1'(xb_im_q);
    sub_re   = W1'(xa_re_q) - W1'(xb_re_q);
    sub_im   = W1'(xa_im_q) - W1'(xb_im_q);
    sum_re_d = MSB'(add_re >>> 1);
    sum_im_d = MSB'(add_im >>> 1);
    d_re     = MSB'(sub_re >>> 1);
    d_im     = MSB'(sub_im >>> 1);
    // 3-multiplier form: Z is shared between both output components
    dd       = W1'(d_re) - W1'(d_im);
    z        = ZW'(c_s) * ZW'(dd);
    pre_re   = PW'(cms_s) * PW'(d_im) + PW'(z);
    pre_im   = PW'(cps_s) * PW'(d_re) - PW'(z);
    bf_re_d  = MSB'(pre_re >>> FRAC);
    bf_im_d  = MSB'(pre_im >>> FRAC);
  end

  // buffer is deliberately left out of reset so coefficients survive an abort
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD && coef_we_i)
      coef_mem_q[coef_addr_i] <= {c_i, cps_i, cms_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      xa_re_q <= '0;
      xa_im_q <= '0;
      xb_re_q <= '0;
      xb_im_q <= '0;
      bf_re_q <= '0;
      bf_im_q <= '0;
      wd_re_q <= '0;
      wd_im_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            stage_q <= stage_i;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (coef_done_i) begin
            raddr_q <= a_d;
            state_q <= S_RD_A;
          end
        end
        S_RD_A: begin
          raddr_q <= b_d;
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          xa_re_q <= mem_rdata_re_i;
          xa_im_q <= mem_rdata_im_i;
          state_q <= S_CAP_B;
        end
        S_CAP_B: begin
          xb_re_q <= mem_rdata_re_i;
          xb_im_q <= mem_rdata_im_i;
          state_q <= S_MUL;
        end
        S_MUL: begin
          bf_re_q <= bf_re_d;
          bf_im_q <= bf_im_d;
          wd_re_q <= sum_re_d;
          wd_im_q <= sum_im_d;
          waddr_q <= a_d;
          we_q    <= 1'b1;
          state_q <= S_WR_A;
        end
        S_WR_A: begin
          wd_re_q <= bf_re_q;
          wd_im_q <= bf_im_q;
          waddr_q <= b_d;
          we_q    <= 1'b1;
          state_q <= S_WR_B;
        end
        S_WR_B: begin
          if (k_q == K_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q     <= k_nxt_d;
            raddr_q <= a_nxt_d;
            state_q <= S_RD_A;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_raddr_o    = raddr_q;
  assign mem_we_o       = we_q;
  assign mem_waddr_o    = waddr_q;
  assign mem_wdata_re_o = wd_re_q;
  assign mem_wdata_im_o = wd_im_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: doc/fft_butterfly_stage.md
# fft_butterfly_stage

Consumer end of the twiddle-coefficient stream for the FFT32 datapath. It captures the coefficient triples (c, c+s, c−s) that the coefficient mapper writes for one stage into a local buffer. When the mapper signals completion, it runs all N/2 radix-2 decimation-in-frequency butterflies of that stage against an external complex sample RAM, using the 3-multiplier complex product. One invocation processes one stage in place.

## Interface
- N, 32, FFT length (power of 2, ≥8)
- MSB, 16, width of each data and coefficient word (signed)
- FRAC, 7, fractional bits of coefficients (127 ≈ 1.0)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a stage; sampled only in IDLE
- stage  in  $clog2(N/4)  stage index s, 0..log2(N)−1; latched on start
- coef_we  in  1  coefficient write strobe from mapper
- coef_addr  in  $clog2(N/2)  butterfly index k of the triple being written
- c_in, cps_in, cms_in  in  MSB each  C, C+S, C−S for index k (W = C + jS)
- coef_done  in  1  mapper's data_valid: all N/2 triples written
- mem_raddr  out  $clog2(N)  sample RAM read address (1-cycle read latency)
- mem_rdata_re, mem_rdata_im  in  MSB each  read data
- mem_we  out  1  sample RAM write enable
- mem_waddr  out  $clog2(N)  write address
- mem_wdata_re, mem_wdata_im  out  MSB each  write data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of stage

## Operation
- States: IDLE, LOAD, RD_A, RD_B, CAP_B, MUL, WR_A, WR_B, DONE.
- IDLE: on start, latch stage, clear k → LOAD. Other inputs are ignored.
- LOAD: each cycle with coef_we, write {c_in, cps_in, cms_in} to buffer[coef_addr]. On coef_done → RD_A. A coef_we in the same cycle as coef_done is still captured. coef_we outside LOAD is ignored.
- Addressing for butterfly k, stage s: half = N>>(s+1); j = k mod half; g = k / half; a = 2·half·g + j; b = a + half. The coefficient used is buffer[k].
- RD_A: mem_raddr=a. RD_B: mem_raddr=b; latch mem_rdata as xa. CAP_B: latch mem_rdata as xb.
- MUL (all signed, full precision, results registered):
  - sum = (xa+xb)>>>1 and d = (xa−xb)>>>1, per component, truncated to MSB.
  - Z = C·(d_re − d_im)
  - B_re = (cms·d_im + Z)>>>FRAC
  - B_im = (cps·d_re − Z)>>>FRAC
  - Results are truncated to the low MSB bits; wraparound, no saturation.
- WR_A: mem_we=1, mem_waddr=a, wdata=sum.
- WR_B: mem_we=1, mem_waddr=b, wdata=B. If k=N/2−1 → DONE; else k+1 → RD_A.
- DONE: done=1 for one cycle → IDLE.
- start during busy is ignored.
- rst in any state → IDLE next edge; the stage is abandoned and no further mem_we is issued. The buffer contents are not cleared.

## Timing
- Reset values: busy=0, done=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_wdata_re/im=0.
- The state advances every cycle outside IDLE and LOAD; there are no stalls.
- 6 cycles per butterfly. If coef_done is sampled in cycle 0, RD_A for k=0 is in cycle 1, the last WR_B is in cycle 3N, and done is high in cycle 3N+1 (97 for N=32).
- mem_we is high only in WR_A and WR_B. mem_raddr holds its last value outside RD_A and RD_B.
- Same-address read and write never overlap within a butterfly. The RAM must return old data for its 1-cycle-latency read.

## Test plan
- Reset: assert rst in MUL mid-stage → next cycle busy=0, mem_we=0, done=0. No write follows, including after rst deasserts.
- Unity twiddle: N=32, s=0, buffer[0]=(127,127,127), x[0]=(100,0), x[16]=(20,0) → writes x[0]=(60,0), x[16]=(39,0).
- Rotation: buffer[1]=(124,100,148), x[1]=(0,0), x[17]=(−64,0) → writes x[1]=(−32,0), x[17]=(31,−6).
- Address map: s=2, k=5 → reads and writes at a=9, b=13. s=4, k=5 → a=10, b=11.
- Load boundary: coef_we with coef_addr=15 in the same cycle as coef_done → triple 15 is stored and used for k=15. coef_we while in IDLE leaves the buffer unchanged.
- Full stage: coef_done at cycle 0 → exactly 32 mem_we pulses, done only at cycle 97. start asserted at cycle 50 has no effect.
